// File: rtl/cart_dongle_lfsr.sv
// rtl/cart_dongle_lfsr.sv - cartridge copy-protection dongle engine
// Key reload, Galois LFSR step, address XOR and invert, selected by the address latched at strobe fall.
module cart_dongle_lfsr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED      = 8'h00,
  parameter logic [WIDTH-1:0] POLY      = 8'hB8,
  parameter logic [7:0]       KEY_ADDR  = 8'hD8,
  parameter int               SHIFT_BIT = 0,
  parameter int               XOR_BIT   = 3,
  parameter int               INV_BIT   = 4,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rom3_n,
  input  logic             uds_n,
  input  logic [7:0]       A,
  output logic [WIDTH-1:0] D,
  output logic             d_oe,
  output logic [CNT_W-1:0] access_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             uds_dly_q;
  logic [7:0]       a_q, a_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             oe_q, oe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fall, rise, start;
  logic [WIDTH-1:0] a_w, s_shift, s_xor, s_next;

  // Latched address zero-extended or truncated to the state width.
  if (WIDTH > 8) begin : g_wide
    assign a_w = {{(WIDTH-8){1'b0}}, a_q};
  end else begin : g_narrow
    assign a_w = a_q[WIDTH-1:0];
  end

  always_comb begin
    fall  = uds_dly_q & ~uds_n;
    rise  = ~uds_dly_q & uds_n;
    start = fall & ~rom3_n & enable;
  end

  always_comb begin
    s_shift = dat_q;
    if (a_q[SHIFT_BIT]) begin
      s_shift = dat_q[0] ? ((dat_q >> 1) ^ POLY) : (dat_q >> 1);
    end
    s_xor  = a_q[XOR_BIT] ? (s_shift ^ a_w) : s_shift;
    s_next = a_q[INV_BIT] ? ~s_xor : s_xor;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (enable) begin
          if (a_q == KEY_ADDR) begin
            dat_d = SEED;
            cnt_d = '0;
          end else begin
            dat_d = s_next;
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
        // A new strobe may begin while the previous one commits.
        if (start) begin
          a_d     = A;
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
    oe_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      uds_dly_q <= 1'b1;
      a_q       <= '0;
      dat_q     <= SEED;
      oe_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      uds_dly_q <= uds_n;
      a_q       <= a_d;
      dat_q     <= dat_d;
      oe_q      <= oe_d;
      cnt_q     <= cnt_d;
    end
  end

  assign D            = dat_q;
  assign d_oe         = oe_q;
  assign access_count = cnt_q;

endmodule

// File: tb/tb_cart_dongle_lfsr.sv
// tb/tb_cart_dongle_lfsr.sv - scoreboard bench for cart_dongle_lfsr
// Two instances share stimulus; the second uses a 2-bit access counter.
module tb_cart_dongle_lfsr;

  logic       clk = 1'b0;
  logic       reset, enable, rom3_n, uds_n;
  logic [7:0] A;
  logic [7:0] D, D2;
  logic       d_oe, d_oe2;
  logic [7:0] access_count;
  logic [1:0] access_count2;

  always #5 clk = ~clk;

  cart_dongle_lfsr u_dut (
    .clk(clk), .reset(reset), .enable(enable), .rom3_n(rom3_n), .uds_n(uds_n),
    .A(A), .D(D), .d_oe(d_oe), .access_count(access_count)
  );

  cart_dongle_lfsr #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .rom3_n(rom3_n), .uds_n(uds_n),
    .A(A), .D(D2), .d_oe(d_oe2), .access_count(access_count2)
  );

  typedef struct {
    int d;
    int cnt;
    int cnt2;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int md = 0, mc = 0, mc2 = 0;
  int oe_rises = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour from the update rules, in plain integer arithmetic.
  function automatic int model_next(input int d, input int a);
    int s;
    if (a == 'hD8) return 0;
    s = d;
    if (a % 2 == 1) s = (s % 2 == 1) ? ((s / 2) ^ 'hB8) : (s / 2);
    if ((a / 8) % 2 == 1) s = s ^ a;
    if ((a / 16) % 2 == 1) s = 255 - s;
    return s;
  endfunction

  // Monitor: each end of a d_oe pulse is followed one cycle later by the settled state.
  bit   prev_oe = 0, prev_oe2 = 0, pending = 0;
  int   run = 0, run2 = 0, saved_len = 0, saved_len2 = 0;
  exp_t e;

  always @(negedge clk) begin
    if (pending) begin
      pending = 0;
      if (exp_q.size() == 0) begin
        chk("unexpected_access", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("D", int'(D), e.d);
        chk("D_cnt2_inst", int'(D2), e.d);
        chk("access_count", int'(access_count), e.cnt);
        chk("access_count_sat2", int'(access_count2), e.cnt2);
        chk("d_oe_len", saved_len, e.len);
        chk("d_oe_len_inst2", saved_len2, e.len);
      end
    end
    if (d_oe && !prev_oe) oe_rises++;
    if (d_oe) run++;
    else if (prev_oe) begin
      pending   = 1;
      saved_len = run;
      run       = 0;
    end
    if (d_oe2) run2++;
    else if (prev_oe2) begin
      saved_len2 = run2;
      run2       = 0;
    end
    prev_oe  = d_oe;
    prev_oe2 = d_oe2;
  end

  // One committed access: uds_n low for k cycles, then high for h cycles.
  task automatic access(input int a, input int k, input int h, input int a_late, input bit wiggle);
    exp_t x;
    @(negedge clk);
    A = 8'(a); rom3_n = 1'b0; uds_n = 1'b0;
    md = model_next(md, a);
    if (a == 'hD8) begin
      mc = 0; mc2 = 0;
    end else begin
      mc  = (mc  < 255) ? mc + 1  : 255;
      mc2 = (mc2 < 3)   ? mc2 + 1 : 3;
    end
    x.d = md; x.cnt = mc; x.cnt2 = mc2; x.len = k;
    exp_q.push_back(x);
    @(posedge clk);
    #1 A = 8'(a_late);
    if (wiggle) rom3_n = 1'($urandom_range(0, 1));
    repeat (k - 1) @(posedge clk);
    @(negedge clk);
    uds_n = 1'b1; rom3_n = 1'b0;
    repeat (h) @(posedge clk);
  endtask

  // Strobe that must not start an access (rom3_n high or enable low at fall).
  task automatic blocked(input int a, input logic r, input logic en);
    int rises0;
    rises0 = oe_rises;
    @(negedge clk);
    A = 8'(a); rom3_n = r; enable = en; uds_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    uds_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rom3_n = 1'b0; enable = 1'b1;
    chk("blocked_no_oe", oe_rises, rises0);
    chk("blocked_D", int'(D), md);
    chk("blocked_count", int'(access_count), mc);
  endtask

  initial begin
    exp_t x;
    reset = 1'b1; enable = 1'b1; rom3_n = 1'b1; uds_n = 1'b1; A = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_D", int'(D), 0);
    chk("reset_d_oe", int'(d_oe), 0);
    chk("reset_count", int'(access_count), 0);
    chk("reset_count2", int'(access_count2), 0);

    access('h00, 4, 3, 'h00, 0);
    access('h10, 2, 2, 'h10, 0);
    access('h01, 3, 2, 'h01, 0);
    access('h08, 1, 2, 'h08, 0);
    access('h19, 2, 2, 'h19, 0);
    access('hD8, 2, 2, 'hD8, 0);

    blocked('h10, 1'b1, 1'b1);
    access('h10, 3, 2, 'h01, 0);

    // Reset while ACTIVE: reset values win, following rise is ignored.
    @(negedge clk);
    A = 8'h10; rom3_n = 1'b0; uds_n = 1'b0;
    md = 0; mc = 0; mc2 = 0;
    x.d = 0; x.cnt = 0; x.cnt2 = 0; x.len = 2;
    exp_q.push_back(x);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; rom3_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_d_oe", int'(d_oe), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    uds_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rom3_n = 1'b0;

    blocked('h10, 1'b0, 1'b0);

    access('h10, 2, 2, 'h10, 0);
    // enable drops while ACTIVE: access abandoned with no update.
    @(negedge clk);
    A = 8'h10; rom3_n = 1'b0; uds_n = 1'b0;
    x.d = md; x.cnt = mc; x.cnt2 = mc2; x.len = 2;
    exp_q.push_back(x);
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    uds_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(posedge clk);

    // Counter saturation on the 2-bit instance, back-to-back strobes.
    for (int i = 0; i < 5; i++) access('h00, 2, 1, 'h00, 0);
    access('h01, 1, 1, 'h01, 0);
    access('h10, 1, 2, 'h10, 0);

    for (int i = 0; i < 60; i++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? 'hD8 : int'($urandom_range(0, 255));
      access(a, $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 255), 1'b1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
